// File: rtl/calc_key_pkg.sv
// Shared types and key codes for the calculator Input Unit key sequencer.
// Optional feature macro used by the consumers of this package: KEY_BKSP_EN.
package calc_key_pkg;

    // Decoded keypad codes; 0-9 are plain digits.
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_ADD  = 5'd10;
    localparam logic [4:0] KEY_SUB  = 5'd11;
    localparam logic [4:0] KEY_MUL  = 5'd12;
    localparam logic [4:0] KEY_DIV  = 5'd13;
    localparam logic [4:0] KEY_EQ   = 5'd14;
    localparam logic [4:0] KEY_CLR  = 5'd15;
    localparam logic [4:0] KEY_BKSP = 5'd16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        RESULT  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        ACT_IDLE    = 2'd0,
        ACT_TRIG_HI = 2'd1,
        ACT_TRIG_LO = 2'd2,
        ACT_CLR     = 2'd3
    } act_e;

    function automatic logic is_operator(input logic [4:0] code);
        return (code >= KEY_ADD) && (code <= KEY_DIV);
    endfunction

    function automatic op_e key_to_op(input logic [4:0] code);
        op_e op;
        case (code)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sr_action_seq.sv
// Shift-register action sequencer: one trigger pulse (high then low) or one
// clear cycle per request, with a ready flag that is high only when idle.
module sr_action_seq
    import calc_key_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_start_trig,
    input  logic i_start_clr,
    output logic o_ready,
    output logic o_sr_trig,
    output logic o_sr_clr_n
);

    act_e r_state;
    act_e w_next;
    logic r_clr_n;

    // State register; the clear strobe is registered so it is held low in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACT_IDLE;
            r_clr_n <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_next;
            r_clr_n <= (w_next != ACT_CLR);
        end
    end

    // Next-state decode: a clear request wins over a trigger request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACT_IDLE: begin
                if (i_start_clr) begin
                    w_next = ACT_CLR;
                end else if (i_start_trig) begin
                    w_next = ACT_TRIG_HI;
                end
            end
            ACT_TRIG_HI: w_next = ACT_TRIG_LO;
            ACT_TRIG_LO: w_next = ACT_IDLE;
            ACT_CLR:     w_next = ACT_IDLE;
            default:     w_next = ACT_IDLE;
        endcase
    end

    assign o_ready    = (r_state == ACT_IDLE);
    assign o_sr_trig  = (r_state == ACT_TRIG_HI);
    assign o_sr_clr_n = r_clr_n;

endmodule

// File: rtl/key_entry_ctrl.sv
// Key entry controller: turns decoded keypad codes into shift-register
// actions and captures operand A, operator and operand B for the execution unit.
// Optional backspace support is enabled by defining KEY_BKSP_EN.
module key_entry_ctrl
    import calc_key_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [4:0]                 key_code,
    output logic                       key_ready,
    input  logic [COUNT*WIDTH-1:0]     sr_out,
    output logic                       sr_trig,
    output logic                       sr_dir,
    output logic [WIDTH-1:0]           sr_in,
    output logic                       sr_clr_n,
    output logic [$clog2(COUNT+1)-1:0] digit_count,
    output logic [COUNT*WIDTH-1:0]     operand_a,
    output logic [COUNT*WIDTH-1:0]     operand_b,
    output logic [1:0]                 op_code,
    output logic                       calc_start,
    output logic [1:0]                 entry_phase,
    output logic                       overflow
);

    localparam int CW = $clog2(COUNT + 1);
    localparam int DW = COUNT * WIDTH;
    localparam logic [CW-1:0] COUNT_MAX = CW'(COUNT);

    phase_e          r_phase,   w_phase_nx;
    logic [CW-1:0]   r_count,   w_count_nx;
    logic            r_ovf,     w_ovf_nx;
    logic [DW-1:0]   r_op_a,    w_op_a_nx;
    logic [DW-1:0]   r_op_b,    w_op_b_nx;
    op_e             r_op,      w_op_nx;
    logic            r_calc,    w_calc_nx;
    logic [WIDTH-1:0] r_in,     w_in_nx;
    logic            r_pend,    w_pend_nx;
    logic [3:0]      r_pend_d,  w_pend_d_nx;
`ifdef KEY_BKSP_EN
    logic            r_dir,     w_dir_nx;
`endif

    logic       w_seq_ready;
    logic       w_start_trig;
    logic       w_clear;
    logic       w_take;
    logic [4:0] w_code;

    // A digit typed in RESULT is parked while the clear runs, then replayed.
    assign key_ready = w_seq_ready && !r_pend;
    assign w_take    = (key_valid && key_ready) || (r_pend && w_seq_ready);
    assign w_code    = r_pend ? {1'b0, r_pend_d} : key_code;

    sr_action_seq u_seq (
        .clk          (clk),
        .reset        (reset),
        .i_start_trig (w_start_trig),
        .i_start_clr  (w_clear),
        .o_ready      (w_seq_ready),
        .o_sr_trig    (sr_trig),
        .o_sr_clr_n   (sr_clr_n)
    );

    // Key decode: decide the next phase, counters, captures and shift action.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_phase_nx   = r_phase;
        w_count_nx   = r_count;
        w_ovf_nx     = r_ovf;
        w_op_a_nx    = r_op_a;
        w_op_b_nx    = r_op_b;
        w_op_nx      = r_op;
        w_calc_nx    = 1'b0;
        w_in_nx      = r_in;
        w_pend_nx    = r_pend;
        w_pend_d_nx  = r_pend_d;
        w_start_trig = 1'b0;
        w_clear      = 1'b0;
`ifdef KEY_BKSP_EN
        w_dir_nx     = r_dir;
`endif
        if (w_take) begin
            w_pend_nx = 1'b0;
            if (w_code <= KEY_9) begin
                if (r_phase == RESULT) begin
                    w_clear     = 1'b1;
                    w_pend_nx   = 1'b1;
                    w_pend_d_nx = w_code[3:0];
                end else if (r_count == '0 && w_code[3:0] == 4'd0) begin
                    // Leading zero carries no value; nothing to shift.
                end else if (r_count == COUNT_MAX) begin
                    w_ovf_nx = 1'b1;
                end else begin
`ifdef KEY_BKSP_EN
                    w_dir_nx     = 1'b0;
`endif
                    w_in_nx      = WIDTH'(w_code[3:0]);
                    w_count_nx   = r_count + 1'b1;
                    w_start_trig = 1'b1;
                end
            end else if (is_operator(w_code)) begin
                if (r_phase == ENTRY_A) begin
                    w_op_a_nx  = sr_out;
                    w_op_nx    = key_to_op(w_code);
                    w_phase_nx = ENTRY_B;
                    w_count_nx = '0;
                    w_clear    = 1'b1;
                end else if (r_phase == ENTRY_B && r_count == '0) begin
                    w_op_nx = key_to_op(w_code);
                end
            end else if (w_code == KEY_EQ) begin
                if (r_phase == ENTRY_B) begin
                    w_op_b_nx  = sr_out;
                    w_calc_nx  = 1'b1;
                    w_phase_nx = RESULT;
                end
            end else if (w_code == KEY_CLR) begin
                w_clear = 1'b1;
`ifdef KEY_BKSP_EN
            end else if (w_code == KEY_BKSP) begin
                if (r_phase != RESULT && r_count != '0) begin
                    w_dir_nx     = 1'b1;
                    w_in_nx      = '0;
                    w_count_nx   = r_count - 1'b1;
                    w_start_trig = 1'b1;
                end
`endif
            end
        end
        // Full clear; an operator in ENTRY_A only borrows the clear strobe.
        if (w_clear && !(w_take && is_operator(w_code))) begin
            w_phase_nx = ENTRY_A;
            w_count_nx = '0;
            w_ovf_nx   = 1'b0;
            w_op_a_nx  = '0;
            w_op_b_nx  = '0;
            w_op_nx    = OP_ADD;
        end
    end

    // Controller registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase  <= ENTRY_A;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op     <= OP_ADD;
            r_calc   <= 1'b0;
            r_in     <= '0;
            r_pend   <= 1'b0;
            r_pend_d <= '0;
`ifdef KEY_BKSP_EN
            r_dir    <= 1'b0;
`endif
        end else begin
            r_phase  <= w_phase_nx;
            r_count  <= w_count_nx;
            r_ovf    <= w_ovf_nx;
            r_op_a   <= w_op_a_nx;
            r_op_b   <= w_op_b_nx;
            r_op     <= w_op_nx;
            r_calc   <= w_calc_nx;
            r_in     <= w_in_nx;
            r_pend   <= w_pend_nx;
            r_pend_d <= w_pend_d_nx;
`ifdef KEY_BKSP_EN
            r_dir    <= w_dir_nx;
`endif
        end
    end

`ifdef KEY_BKSP_EN
    assign sr_dir = r_dir;
`else
    assign sr_dir = 1'b0;
`endif
    assign sr_in       = r_in;
    assign digit_count = r_count;
    assign operand_a   = r_op_a;
    assign operand_b   = r_op_b;
    assign op_code     = r_op;
    assign calc_start  = r_calc;
    assign entry_phase = r_phase;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed self-checking bench for key_entry_ctrl with a behavioural
// model of the BCD shift register driving sr_out.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        key_ready;
    logic [15:0] sr_out;
    logic        sr_trig;
    logic        sr_dir;
    logic [3:0]  sr_in;
    logic        sr_clr_n;
    logic [2:0]  digit_count;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  op_code;
    logic        calc_start;
    logic [1:0]  entry_phase;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;
    int n_trig  = 0;
    int n_calc  = 0;
    int n_clr   = 0;

    logic [15:0] sr_model;

    always #5 clk = ~clk;

    key_entry_ctrl #(.COUNT(4), .WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .sr_out      (sr_out),
        .sr_trig     (sr_trig),
        .sr_dir      (sr_dir),
        .sr_in       (sr_in),
        .sr_clr_n    (sr_clr_n),
        .digit_count (digit_count),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .calc_start  (calc_start),
        .entry_phase (entry_phase),
        .overflow    (overflow)
    );

    // Shift register model: shifts on the trigger's rising edge, clears while sr_clr_n is low.
    always @(posedge sr_trig or negedge sr_clr_n) begin
        if (!sr_clr_n)   sr_model <= 16'h0000;
        else if (sr_dir) sr_model <= {4'h0, sr_model[15:4]};
        else             sr_model <= {sr_model[11:0], sr_in};
    end
    assign sr_out = sr_model;

    always @(posedge sr_trig) n_trig++;

    always @(posedge clk) begin
        if (calc_start) n_calc++;
        if (reset && !sr_clr_n) n_clr++;
    end

    task automatic wait_idle();
        int k = 0;
        while (key_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (key_ready !== 1'b1) begin
            n_total++; n_bad++;
            $display("FAIL ready_timeout: key_ready=%b after %0d cycles, want 1", key_ready, k);
        end
    endtask

    task automatic press_key(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({key_ready, sr_trig, sr_clr_n, calc_start, overflow, sr_dir, sr_in} !== 10'b10_0000_0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 1000000000",
                {key_ready, sr_trig, sr_clr_n, calc_start, overflow, sr_dir, sr_in});
        end
        n_total++;
        if ({entry_phase, digit_count, op_code, operand_a, operand_b} !== 39'd0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0",
                {entry_phase, digit_count, op_code, operand_a, operand_b});
        end
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({sr_clr_n, key_ready} !== 2'b11) begin
            n_bad++; $display("FAIL reset_release: clr_n,ready got %b want 11", {sr_clr_n, key_ready});
        end
    endtask

    task automatic test_digits();
        int t0;
        t0 = n_trig;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd1;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++;
        if ({sr_trig, key_ready, sr_dir, sr_in, digit_count} !== {1'b1, 1'b0, 1'b0, 4'd1, 3'd1}) begin
            n_bad++; $display("FAIL digit_n1: trig,ready,dir,in,count got %b want 1000001001",
                {sr_trig, key_ready, sr_dir, sr_in, digit_count});
        end
        @(negedge clk);
        n_total++;
        if ({sr_trig, key_ready, sr_in} !== {1'b0, 1'b0, 4'd1}) begin
            n_bad++; $display("FAIL digit_n2: trig,ready,in got %b want 000001", {sr_trig, key_ready, sr_in});
        end
        @(negedge clk);
        n_total++;
        if (key_ready !== 1'b1) begin
            n_bad++; $display("FAIL digit_n3: key_ready got %b want 1", key_ready);
        end
        press_key(5'd2);
        press_key(5'd3);
        n_total++;
        if ({n_trig - t0, sr_in, sr_dir, digit_count, sr_model} !== {32'd3, 4'd3, 1'b0, 3'd3, 16'h0123}) begin
            n_bad++; $display("FAIL digits_123: trig=%0d in=%0d dir=%b count=%0d sr=%h want 3 3 0 3 0123",
                n_trig - t0, sr_in, sr_dir, digit_count, sr_model);
        end
        press_key(5'd15);
    endtask

    task automatic test_leading_zero();
        int t0;
        t0 = n_trig;
        press_key(5'd0);
        press_key(5'd0);
        press_key(5'd7);
        n_total++;
        if ({n_trig - t0, digit_count, sr_model} !== {32'd1, 3'd1, 16'h0007}) begin
            n_bad++; $display("FAIL leading_zero: trig=%0d count=%0d sr=%h want 1 1 0007",
                n_trig - t0, digit_count, sr_model);
        end
        press_key(5'd15);
    endtask

    task automatic test_overflow_clr();
        int t0, c0;
        t0 = n_trig;
        for (int d = 1; d <= 5; d++) press_key(5'(d));
        n_total++;
        if ({n_trig - t0, digit_count, overflow, sr_model} !== {32'd4, 3'd4, 1'b1, 16'h1234}) begin
            n_bad++; $display("FAIL overflow: trig=%0d count=%0d ovf=%b sr=%h want 4 4 1 1234",
                n_trig - t0, digit_count, overflow, sr_model);
        end
        c0 = n_clr;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd15;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++;
        if ({sr_clr_n, overflow, digit_count, key_ready} !== 6'b000000) begin
            n_bad++; $display("FAIL clr_n1: clr_n,ovf,count,ready got %b want 000000",
                {sr_clr_n, overflow, digit_count, key_ready});
        end
        @(negedge clk);
        n_total++;
        if ({sr_clr_n, key_ready, n_clr - c0, sr_model} !== {1'b1, 1'b1, 32'd1, 16'h0}) begin
            n_bad++; $display("FAIL clr_n2: clr_n=%b ready=%b low_cycles=%0d sr=%h want 1 1 1 0000",
                sr_clr_n, key_ready, n_clr - c0, sr_model);
        end
    endtask

    task automatic test_calc_flow();
        int c0;
        c0 = n_calc;
        press_key(5'd1);
        press_key(5'd2);
        press_key(5'd10);
        n_total++;
        if ({entry_phase, digit_count, operand_a, op_code, sr_model} !== {2'd1, 3'd0, 16'h0012, 2'd0, 16'h0}) begin
            n_bad++; $display("FAIL op_add: phase=%0d count=%0d a=%h op=%0d sr=%h want 1 0 0012 0 0000",
                entry_phase, digit_count, operand_a, op_code, sr_model);
        end
        press_key(5'd11);
        n_total++;
        if ({op_code, entry_phase} !== {2'd1, 2'd1}) begin
            n_bad++; $display("FAIL op_correct: op=%0d phase=%0d want 1 1", op_code, entry_phase);
        end
        press_key(5'd3);
        press_key(5'd4);
        press_key(5'd12);
        n_total++;
        if (op_code !== 2'd1) begin
            n_bad++; $display("FAIL op_ignored: op=%0d want 1", op_code);
        end
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd14;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++;
        if ({calc_start, entry_phase, operand_a, operand_b, op_code} !== {1'b1, 2'd2, 16'h0012, 16'h0034, 2'd1}) begin
            n_bad++; $display("FAIL eq: start=%b phase=%0d a=%h b=%h op=%0d want 1 2 0012 0034 1",
                calc_start, entry_phase, operand_a, operand_b, op_code);
        end
        @(negedge clk);
        n_total++;
        if (calc_start !== 1'b0) begin
            n_bad++; $display("FAIL eq_pulse: calc_start got %b want 0", calc_start);
        end
        press_key(5'd5);
        n_total++;
        if ({entry_phase, digit_count, sr_model, operand_a, operand_b, op_code} !== {2'd0, 3'd1, 16'h0005, 32'd0, 2'd0}) begin
            n_bad++; $display("FAIL result_digit: phase=%0d count=%0d sr=%h a=%h b=%h op=%0d want 0 1 0005 0 0 0",
                entry_phase, digit_count, sr_model, operand_a, operand_b, op_code);
        end
        press_key(5'd14);
        n_total++;
        if ({entry_phase, n_calc - c0} !== {2'd0, 32'd1}) begin
            n_bad++; $display("FAIL eq_in_a: phase=%0d pulses=%0d want 0 1", entry_phase, n_calc - c0);
        end
        press_key(5'd15);
    endtask

    task automatic test_bksp();
        int t0;
        press_key(5'd4);
        press_key(5'd5);
`ifdef KEY_BKSP_EN
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd16;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++;
        if ({sr_trig, sr_dir, sr_in, digit_count} !== {1'b1, 1'b1, 4'd0, 3'd1}) begin
            n_bad++; $display("FAIL bksp: trig,dir,in,count got %b want 110000001",
                {sr_trig, sr_dir, sr_in, digit_count});
        end
        wait_idle();
        n_total++;
        if (sr_model !== 16'h0004) begin
            n_bad++; $display("FAIL bksp_sr: sr=%h want 0004", sr_model);
        end
        press_key(5'd16);
        t0 = n_trig;
        press_key(5'd16);
        n_total++;
        if ({n_trig - t0, digit_count, sr_model} !== {32'd0, 3'd0, 16'h0}) begin
            n_bad++; $display("FAIL bksp_empty: trig=%0d count=%0d sr=%h want 0 0 0000",
                n_trig - t0, digit_count, sr_model);
        end
`else
        t0 = n_trig;
        press_key(5'd16);
        n_total++;
        if ({n_trig - t0, sr_dir, digit_count, sr_model} !== {32'd0, 1'b0, 3'd2, 16'h0045}) begin
            n_bad++; $display("FAIL bksp_off: trig=%0d dir=%b count=%0d sr=%h want 0 0 2 0045",
                n_trig - t0, sr_dir, digit_count, sr_model);
        end
`endif
        press_key(5'd15);
    endtask

    task automatic test_drop_while_busy();
        int t0;
        t0 = n_trig;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd8;
        repeat (3) @(negedge clk);
        key_valid = 1'b0;
        wait_idle();
        press_key(5'd20);
        press_key(5'd31);
        n_total++;
        if ({n_trig - t0, digit_count, sr_model} !== {32'd1, 3'd1, 16'h0008}) begin
            n_bad++; $display("FAIL busy_drop: trig=%0d count=%0d sr=%h want 1 1 0008",
                n_trig - t0, digit_count, sr_model);
        end
        press_key(5'd15);
    endtask

    task automatic test_reset_mid();
        press_key(5'd1);
        press_key(5'd10);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 5'd9;
        @(negedge clk);
        key_valid = 1'b0;
        n_total++;
        if ({sr_trig, entry_phase} !== {1'b1, 2'd1}) begin
            n_bad++; $display("FAIL pre_reset: trig=%b phase=%0d want 1 1", sr_trig, entry_phase);
        end
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({sr_trig, sr_clr_n, key_ready, entry_phase, digit_count, operand_a, op_code} !==
            {1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 16'h0, 2'd0}) begin
            n_bad++; $display("FAIL mid_reset: trig=%b clr_n=%b ready=%b phase=%0d count=%0d a=%h op=%0d want 0 0 1 0 0 0 0",
                sr_trig, sr_clr_n, key_ready, entry_phase, digit_count, operand_a, op_code);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({sr_clr_n, key_ready, sr_trig} !== 3'b110) begin
            n_bad++; $display("FAIL mid_release: clr_n,ready,trig got %b want 110", {sr_clr_n, key_ready, sr_trig});
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_leading_zero();
        test_overflow_clr();
        test_calc_flow();
        test_bksp();
        test_drop_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
